// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared state encoding and counter limits for the PLL lock supervisor
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_e;

  localparam logic [7:0] LOSS_CNT_MAX = 8'd255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == LOSS_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// rtl/pll_lock_supervisor_if.sv - lock flag, relock request and supervisor status bundle
interface pll_lock_supervisor_if;
  logic       extlock;
  logic       force_relock;
  logic       pll_reset;
  logic       sys_rst;
  logic       locked;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  modport master (
    output extlock, force_relock,
    input  pll_reset, sys_rst, locked, fail, retry_cnt, lock_loss_cnt
  );

  modport slave (
    input  extlock, force_relock,
    output pll_reset, sys_rst, locked, fail, retry_cnt, lock_loss_cnt
  );
endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - parameterised two-flop synchroniser, async active-high reset to zero
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock qualification, retry and relock control
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 24,
  parameter int LOCK_TIMEOUT_CYCLES = 24000,
  parameter int STABLE_CYCLES       = 2400,
  parameter int MAX_RETRIES         = 8,
  parameter int CNT_W               = 16
) (
  input  logic                  refclk,
  input  logic                  reset,
  pll_lock_supervisor_if.slave  sup
);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [4:0]       RETRY_LIM = 5'(MAX_RETRIES);

  logic             lock_s;
  pll_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       retry_cnt, retry_cnt_d;
  logic [7:0]       loss_cnt, loss_cnt_d;
  logic             attempt_fail;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_rst_q, sys_rst_d;
  logic             locked_q, locked_d;
  logic             fail_q, fail_d;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (refclk),
    .rst (reset),
    .d   (sup.extlock),
    .q   (lock_s)
  );

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      retry_cnt   <= '0;
      loss_cnt    <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      retry_cnt   <= retry_cnt_d;
      loss_cnt    <= loss_cnt_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
    end
  end

  // force_relock outranks timeout and lock drop, so a forced restart never costs a retry
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    retry_cnt_d  = retry_cnt;
    loss_cnt_d   = loss_cnt;
    attempt_fail = 1'b0;
    unique case (state)
      RESET_PLL: begin
        if (sup.force_relock) begin
          cnt_d = '0;
        end else if (cnt == RST_LAST) begin
          cnt_d   = '0;
          state_d = WAIT_LOCK;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (sup.force_relock) begin
          cnt_d   = '0;
          state_d = RESET_PLL;
        end else if (lock_s) begin
          cnt_d   = '0;
          state_d = STABLE;
        end else if (cnt == TO_LAST) begin
          attempt_fail = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      STABLE: begin
        if (sup.force_relock) begin
          cnt_d   = '0;
          state_d = RESET_PLL;
        end else if (!lock_s) begin
          attempt_fail = 1'b1;
        end else if (cnt == STB_LAST) begin
          cnt_d       = '0;
          retry_cnt_d = '0;
          state_d     = RUN;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          loss_cnt_d = sat_inc8(loss_cnt);
        end
        if (!lock_s || sup.force_relock) begin
          cnt_d   = '0;
          state_d = RESET_PLL;
        end
      end
      FAIL: begin
        if (sup.force_relock) begin
          cnt_d       = '0;
          retry_cnt_d = '0;
          state_d     = RESET_PLL;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = RESET_PLL;
      end
    endcase

    if (attempt_fail) begin
      cnt_d = '0;
      if ({1'b0, retry_cnt} + 5'd1 == RETRY_LIM) begin
        retry_cnt_d = 4'(MAX_RETRIES);
        state_d     = FAIL;
      end else begin
        retry_cnt_d = retry_cnt + 4'd1;
        state_d     = RESET_PLL;
      end
    end
  end

  always_comb begin
    pll_reset_d = (state_d == RESET_PLL) || (state_d == FAIL);
    sys_rst_d   = (state_d != RUN);
    locked_d    = (state_d == RUN);
    fail_d      = (state_d == FAIL);
  end

  assign sup.pll_reset     = pll_reset_q;
  assign sup.sys_rst       = sys_rst_q;
  assign sup.locked        = locked_q;
  assign sup.fail          = fail_q;
  assign sup.retry_cnt     = retry_cnt;
  assign sup.lock_loss_cnt = loss_cnt;

endmodule
